// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared state type and oldest-busy-stage priority helper
package pipe_hazard_ctrl_pkg;
  typedef enum logic {RUN, KILL} pipe_state_t;
  localparam int MAX_STAGES = 32;
  function automatic int oldest_busy(input logic [MAX_STAGES-1:0] v);
    oldest_busy = 0;
    for (int i = 0; i < MAX_STAGES; i++) if (v[i]) oldest_busy = i;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller, oldest busy stage freezes younger stages and bubbles behind itself
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STAGES  = 5,
  parameter int REG_W       = 5,
  parameter int DEC_STAGE   = 1,
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 1024,
  localparam int SIDX_W     = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stage_busy,
  input  logic                  imem_resp,
  input  logic                  ld_valid,
  input  logic [REG_W-1:0]      ld_rd,
  input  logic [REG_W-1:0]      id_rs1,
  input  logic [REG_W-1:0]      id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic                  redirect_valid,
  input  logic [SIDX_W-1:0]     redirect_stage,
  output logic                  load_pc,
  output logic                  inst_read,
  output logic [NUM_STAGES-2:0] pipe_load,
  output logic [NUM_STAGES-2:0] pipe_flush,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic                  hang_err
);
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  pipe_state_t           state;
  logic                  load_use, stall, rd_acc;
  logic [NUM_STAGES-1:0] eb;
  logic [WD_W-1:0]       wdog;
  int                    s, rs;
  assign load_use = ld_valid && ld_rd != '0 &&
                    ((id_rs1_used && id_rs1 == ld_rd) || (id_rs2_used && id_rs2 == ld_rd));
  assign eb     = stage_busy | (NUM_STAGES'(load_use) << DEC_STAGE);
  assign s      = oldest_busy(MAX_STAGES'(eb));
  assign rs     = int'(redirect_stage);
  assign stall  = |eb;
  // a redirect must wait until nothing at or beyond its resolving stage is stuck
  assign rd_acc = redirect_valid && (eb >> redirect_stage) == '0;
  always_comb begin
    load_pc    = rst && (rd_acc || !stall);
    inst_read  = rst;
    pipe_load  = '0;
    pipe_flush = '0;
    for (int i = 0; i < NUM_STAGES - 1; i++) begin
      pipe_load[i]  = rst && (rd_acc || !stall || i >= s || (i == 0 && state == KILL));
      pipe_flush[i] = !rst || (rd_acc ? i < rs : stall && i == s) || (i == 0 && state == KILL);
    end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RUN;
    else state <= (state == KILL) ? (imem_resp ? RUN : KILL) : ((rd_acc && stage_busy[0]) ? KILL : RUN);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wdog     <= '0;
      hang_err <= 1'b0;
    end else begin
      wdog <= load_pc ? '0 : (wdog == WD_W'(WDOG_CYCLES) ? wdog : wdog + 1'b1);
      if (!load_pc && wdog >= WD_W'(WDOG_CYCLES - 1)) hang_err <= 1'b1;
    end
  sat_counter #(.WIDTH(CNT_W)) u_stall (.clk(clk), .rst(rst), .inc(!load_pc), .cnt(stall_cnt));
  sat_counter #(.WIDTH(CNT_W)) u_flush (.clk(clk), .rst(rst), .inc(rd_acc), .cnt(flush_cnt));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl (default and 4-bit-counter instances)
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] stage_busy;
  logic       imem_resp, ld_valid, id_rs1_used, id_rs2_used, redirect_valid;
  logic [4:0] ld_rd, id_rs1, id_rs2;
  logic [2:0] redirect_stage;
  logic        load_pc, inst_read, hang_err;
  logic [3:0]  pipe_load, pipe_flush;
  logic [31:0] stall_cnt, flush_cnt;
  logic        s_load_pc, s_inst_read, s_hang_err;
  logic [3:0]  s_pipe_load, s_pipe_flush, s_stall_cnt, s_flush_cnt;
  typedef struct {
    string      tag;
    logic       lp;
    logic [3:0] pl;
    logic [3:0] pf;
  } exp_t;
  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk(clk), .rst(rst), .stage_busy(stage_busy), .imem_resp(imem_resp),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .redirect_valid(redirect_valid), .redirect_stage(redirect_stage),
    .load_pc(load_pc), .inst_read(inst_read), .pipe_load(pipe_load), .pipe_flush(pipe_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hang_err(hang_err)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .stage_busy(stage_busy), .imem_resp(imem_resp),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .redirect_valid(redirect_valid), .redirect_stage(redirect_stage),
    .load_pc(s_load_pc), .inst_read(s_inst_read), .pipe_load(s_pipe_load), .pipe_flush(s_pipe_flush),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .hang_err(s_hang_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // push the expected outputs for the cycle just driven, compare on the falling edge
  task automatic step(input string tag, input logic lp, input logic [3:0] pl, input logic [3:0] pf);
    exp_t e;
    e.tag = tag; e.lp = lp; e.pl = pl; e.pf = pf;
    q.push_back(e);
    @(negedge clk);
    while (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".load_pc"}, 64'(load_pc), 64'(e.lp));
      chk({e.tag, ".inst_read"}, 64'(inst_read), 64'd1);
      chk({e.tag, ".pipe_load"}, 64'(pipe_load), 64'(e.pl));
      chk({e.tag, ".pipe_flush"}, 64'(pipe_flush), 64'(e.pf));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_forced(input string tag);
    chk({tag, ".load_pc"}, 64'(load_pc), 64'd0);
    chk({tag, ".inst_read"}, 64'(inst_read), 64'd0);
    chk({tag, ".pipe_load"}, 64'(pipe_load), 64'h0);
    chk({tag, ".pipe_flush"}, 64'(pipe_flush), 64'hf);
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'd0);
    chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'd0);
    chk({tag, ".hang_err"}, 64'(hang_err), 64'd0);
  endtask

  initial begin
    rst = 1'b0; stage_busy = '0; imem_resp = 1'b0; ld_valid = 1'b0; ld_rd = '0;
    id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    redirect_valid = 1'b0; redirect_stage = '0;
    #2;
    chk_reset_forced("por");
    @(posedge clk); #1;
    rst = 1'b1;
    step("idle0", 1'b1, 4'b1111, 4'b0000);
    step("idle1", 1'b1, 4'b1111, 4'b0000);
    stage_busy = 5'b01000;
    for (int i = 0; i < 10; i++) step("mem_miss", 1'b0, 4'b1000, 4'b1000);
    chk("mem_miss.stall_cnt", 64'(stall_cnt), 64'd10);
    stage_busy = '0;
    step("mem_release", 1'b1, 4'b1111, 4'b0000);
    chk("mem_release.stall_cnt", 64'(stall_cnt), 64'd10);
    ld_valid = 1'b1; ld_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
    step("lu_rs2", 1'b0, 4'b1110, 4'b0010);
    ld_valid = 1'b0;
    step("lu_done", 1'b1, 4'b1111, 4'b0000);
    ld_valid = 1'b1; ld_rd = 5'd0; id_rs2 = 5'd0;
    step("lu_x0", 1'b1, 4'b1111, 4'b0000);
    ld_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b0; id_rs2 = 5'd3;
    step("lu_unused", 1'b1, 4'b1111, 4'b0000);
    id_rs1_used = 1'b1;
    step("lu_rs1", 1'b0, 4'b1110, 4'b0010);
    ld_valid = 1'b0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    chk("lu.stall_cnt", 64'(stall_cnt), 64'd12);
    stage_busy = 5'b00001; redirect_valid = 1'b1; redirect_stage = 3'd2;
    step("rd_kill", 1'b1, 4'b1111, 4'b0011);
    chk("rd_kill.flush_cnt", 64'(flush_cnt), 64'd1);
    redirect_valid = 1'b0;
    step("kill1", 1'b0, 4'b1111, 4'b0001);
    step("kill2", 1'b0, 4'b1111, 4'b0001);
    stage_busy = '0; imem_resp = 1'b1;
    step("kill_resp", 1'b1, 4'b1111, 4'b0001);
    imem_resp = 1'b0;
    step("run_after_kill", 1'b1, 4'b1111, 4'b0000);
    chk("kill.flush_cnt", 64'(flush_cnt), 64'd1);
    chk("kill.stall_cnt", 64'(stall_cnt), 64'd14);
    stage_busy = 5'b01000; redirect_valid = 1'b1; redirect_stage = 3'd2;
    step("rd_blocked0", 1'b0, 4'b1000, 4'b1000);
    step("rd_blocked1", 1'b0, 4'b1000, 4'b1000);
    chk("rd_blocked.flush_cnt", 64'(flush_cnt), 64'd1);
    stage_busy = '0;
    step("rd_accept", 1'b1, 4'b1111, 4'b0011);
    chk("rd_accept.flush_cnt", 64'(flush_cnt), 64'd2);
    stage_busy = 5'b00010;
    step("rd_young_busy", 1'b1, 4'b1111, 4'b0011);
    chk("rd_young_busy.flush_cnt", 64'(flush_cnt), 64'd3);
    redirect_stage = 3'd1;
    step("rd_same_stage_busy", 1'b0, 4'b1110, 4'b0010);
    chk("rd_same_stage_busy.flush_cnt", 64'(flush_cnt), 64'd3);
    redirect_valid = 1'b0; stage_busy = '0;
    step("idle2", 1'b1, 4'b1111, 4'b0000);
    chk("sat.stall_cnt_early", 64'(s_stall_cnt), 64'd15);
    chk("stall_cnt_pre_reset", 64'(stall_cnt), 64'd17);
    stage_busy = 5'b00001; redirect_valid = 1'b1; redirect_stage = 3'd3;
    step("rd_kill2", 1'b1, 4'b1111, 4'b0111);
    redirect_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_reset_forced("mid_rst");
    @(posedge clk); #1;
    rst = 1'b1; stage_busy = '0;
    step("post_rst_run", 1'b1, 4'b1111, 4'b0000);
    stage_busy = 5'b01000;
    repeat (1023) @(posedge clk);
    #1;
    chk("wdog_minus1.hang_err", 64'(hang_err), 64'd0);
    @(posedge clk); #1;
    chk("wdog.hang_err", 64'(hang_err), 64'd1);
    chk("wdog.stall_cnt", 64'(stall_cnt), 64'd1024);
    chk("sat.stall_cnt", 64'(s_stall_cnt), 64'd15);
    stage_busy = '0;
    step("wdog_release", 1'b1, 4'b1111, 4'b0000);
    chk("wdog_sticky.hang_err", 64'(hang_err), 64'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised stall/flush controller for an N-stage in-order pipeline.
- Replaces per-case hand decoding with a generic rule: the oldest busy stage freezes everything younger and inserts a bubble behind itself.
- Adds load-use interlock, deferred redirect with stale-fetch kill FSM, saturating stall/flush performance counters and a hang watchdog.
- Sits beside the datapath and drives PC load, fetch enable and every pipeline register's load/reset.

Parameters:
- NUM_STAGES, 5, stage count; stage 0 = IF, NUM_STAGES-1 = WB; pipeline reg i sits between stage i and i+1.
- REG_W, 5, register index width.
- DEC_STAGE, 1, stage that reads operands; the load producer is stage DEC_STAGE+1.
- CNT_W, 32, performance counter width.
- WDOG_CYCLES, 1024, consecutive PC-stall cycles before hang_err.
- Localparam SIDX_W = $clog2(NUM_STAGES).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- stage_busy  in  NUM_STAGES  bit i: stage i cannot complete this cycle (bit0 = imem request outstanding, MEM = dmem miss, EX = muldiv busy)
- imem_resp  in  1  instruction fetch response this cycle
- ld_valid  in  1  stage DEC_STAGE+1 holds a load
- ld_rd  in  REG_W  that load's destination
- id_rs1, id_rs2  in  REG_W  sources in DEC_STAGE
- id_rs1_used, id_rs2_used  in  1  source actually read
- redirect_valid  in  1  branch/jump taken, resolved in redirect_stage
- redirect_stage  in  SIDX_W  stage index of resolving instruction (1..NUM_STAGES-1)
- load_pc  out  1  PC register enable
- inst_read  out  1  imem read request
- pipe_load  out  NUM_STAGES-1  pipeline register enables
- pipe_flush  out  NUM_STAGES-1  synchronous bubble insert (register loads NOP)
- stall_cnt  out  CNT_W  cycles with load_pc=0
- flush_cnt  out  CNT_W  accepted redirects
- hang_err  out  1  sticky watchdog flag

Behaviour:
- Reset (rst=0, async): state=RUN, counters=0, hang_err=0, watchdog=0. While asserted, outputs are forced: load_pc=0, inst_read=0, pipe_load=0, pipe_flush=all 1.
- Effective busy vector eb = stage_busy, OR bit DEC_STAGE when load-use holds.
- Load-use holds when ld_valid, ld_rd!=0, and ((id_rs1_used && id_rs1==ld_rd) || (id_rs2_used && id_rs2==ld_rd)).
- s = highest set index in eb (the oldest busy stage).
- Stall, when eb!=0 and no accepted redirect:
  - load_pc=0.
  - Regs 0..s-1: load=0 (hold).
  - Reg s (if s<NUM_STAGES-1): load=1, flush=1 (bubble).
  - Regs >s: load=1, flush=0.
- Redirect is accepted only if redirect_valid and no eb bit at index >= redirect_stage is set. Otherwise it is ignored; the producer re-asserts it while held.
- Accepted redirect:
  - load_pc=1.
  - Regs 0..redirect_stage-1: flush=1, load=1.
  - Older regs follow the stall rule for s<redirect_stage; otherwise they load.
  - flush_cnt+1.
- Accepted redirect while stage_busy[0]: FSM RUN->KILL. Outstanding fetch belongs to the wrong path.
- KILL state:
  - inst_read=1 (request stays in flight); reg 0 load=1, flush=1 every cycle.
  - On imem_resp -> RUN; that response is discarded (reg 0 flushed).
  - Redirect in KILL: PC reloads, stay KILL.
- RUN state, normal: inst_read=1, load_pc=!stage_busy[0] unless the stall/redirect rules above apply.
- Counters: stall_cnt +1 each cycle load_pc=0. Both counters saturate at all-ones and never wrap.
- Watchdog:
  - Increments on consecutive load_pc=0 cycles; clears when load_pc=1.
  - Reaching WDOG_CYCLES sets hang_err; hang_err stays set until rst.
- Reset mid-KILL returns to RUN immediately. The next fetch is not discarded.
- All outputs except counters/hang_err are combinational from inputs and state. There is no added latency.

Decomposition:
- Package: pipe_state_t enum {RUN, KILL}, and the oldest-busy-index function.
- Sub-module sat_counter (WIDTH parameter, inc, saturate), instantiated twice.

Test Plan:
- Reset, then idle with no busy: load_pc=1, pipe_load=4'b1111, pipe_flush=0. Assert rst mid-run: outputs forced safe asynchronously, counters=0.
- stage_busy=5'b01000 (MEM miss) for 10 cycles:
  - pipe_load=4'b1000, pipe_flush=4'b1000, load_pc=0.
  - stall_cnt=10.
  - Release: all loads resume the same cycle.
- ld_valid, ld_rd=5, id_rs2=5 used: one-cycle bubble in reg1 (pipe_flush=4'b0010), regs 0 held. Repeat with ld_rd=0: no stall.
- Redirect from stage 2 while stage_busy[0]:
  - flush regs 0,1; load_pc=1; state KILL.
  - imem_resp 3 cycles later: reg 0 flushed, state RUN, flush_cnt=1.
- Redirect from stage 2 with stage_busy[3]: ignored, flush_cnt unchanged. Accepted on the first cycle busy[3] clears.
- Hold stage_busy[3] for WDOG_CYCLES cycles: hang_err=1 and stays 1 after the stall clears. CNT_W=4 override: stall_cnt saturates at 15.
